// File: rtl/uart_prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_prog_loader: 8N1 UART receiver feeding length-prefixed bytes into   |
// | instruction memory; holds the core until the image is complete.          |
// | Optional: define UART_LOADER_CHECKSUM_EN for a trailing XOR check byte.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_prog_loader #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  input  logic              start_load,
  output logic              prog_wr_en,
  output logic [ADDR_W-1:0] prog_wr_addr,
  output logic [7:0]        prog_wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   byte_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [16:0]      CAPACITY = 17'(2 ** ADDR_W);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
`ifdef UART_LOADER_CHECKSUM_EN
    , S_CHK  = 3'd6
`endif
  } ld_state_t;

`ifdef UART_LOADER_CHECKSUM_EN
  localparam ld_state_t S_TAIL = S_CHK;
`else
  localparam ld_state_t S_TAIL = S_DONE;
`endif

  rx_state_t        rx_state_q;
  logic             rx_meta_q;
  logic             rx_sync_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic             rx_valid_q;
  logic             rx_ferr_q;

  ld_state_t        state_q;
  logic [15:0]      len_q;
  logic [ADDR_W:0]  byte_count_q;
  logic             wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]       wr_data_q;
  logic             hold_q;
  logic             done_q;
  logic             err_q;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  logic [15:0]      len_d;
  logic [ADDR_W:0]  byte_count_d;

  assign len_d        = {rx_shift_q, len_q[7:0]};
  assign byte_count_d = byte_count_q + 1'b1;

  // Synchroniser resets high so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_BIT) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == FULL_BIT) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == FULL_BIT) begin
            rx_cnt_q   <= '0;
            rx_valid_q <= rx_sync_q;
            rx_ferr_q  <= !rx_sync_q;
            rx_state_q <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // DONE/ERR drive their flags while resident, so status lags entry by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      byte_count_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      hold_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      if (start_load) begin
        state_q      <= S_LEN_LO;
        len_q        <= '0;
        byte_count_q <= '0;
        hold_q       <= 1'b1;
        done_q       <= 1'b0;
        err_q        <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
        csum_q       <= '0;
`endif
      end else begin
        case (state_q)
          S_IDLE: ;
          S_LEN_LO: begin
            if (rx_ferr_q) begin
              state_q <= S_ERR;
            end else if (rx_valid_q) begin
              len_q[7:0] <= rx_shift_q;
              state_q    <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            if (rx_ferr_q) begin
              state_q <= S_ERR;
            end else if (rx_valid_q) begin
              len_q[15:8] <= rx_shift_q;
              if (len_d == 16'd0)                state_q <= S_TAIL;
              else if ({1'b0, len_d} > CAPACITY) state_q <= S_ERR;
              else                               state_q <= S_DATA;
            end
          end
          S_DATA: begin
            if (rx_ferr_q) begin
              state_q <= S_ERR;
            end else if (rx_valid_q) begin
              wr_en_q      <= 1'b1;
              wr_addr_q    <= byte_count_q[ADDR_W-1:0];
              wr_data_q    <= rx_shift_q;
              byte_count_q <= byte_count_d;
`ifdef UART_LOADER_CHECKSUM_EN
              csum_q       <= csum_q ^ rx_shift_q;
`endif
              if (17'(byte_count_d) == {1'b0, len_q}) state_q <= S_TAIL;
            end
          end
`ifdef UART_LOADER_CHECKSUM_EN
          S_CHK: begin
            if (rx_ferr_q) begin
              state_q <= S_ERR;
            end else if (rx_valid_q) begin
              state_q <= (rx_shift_q == csum_q) ? S_DONE : S_ERR;
            end
          end
`endif
          S_DONE: begin
            done_q <= 1'b1;
            hold_q <= 1'b0;
          end
          S_ERR: begin
            err_q  <= 1'b1;
            hold_q <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign prog_wr_en   = wr_en_q;
  assign prog_wr_addr = wr_addr_q;
  assign prog_wr_data = wr_data_q;
  assign cpu_hold     = hold_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign byte_count   = byte_count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// Bench for uart_prog_loader: directed and random images over a 16-clock/bit
// UART, compared against an arithmetic model of the length-prefixed format.
module tb_uart_prog_loader;
  localparam int ADDR_W = 12;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              uart_rx;
  logic              start_load;
  logic              prog_wr_en;
  logic [ADDR_W-1:0] prog_wr_addr;
  logic [7:0]        prog_wr_data;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   byte_count;

  uart_prog_loader #(.CLK_FREQ(16), .BAUD(1), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .start_load(start_load),
    .prog_wr_en(prog_wr_en), .prog_wr_addr(prog_wr_addr), .prog_wr_data(prog_wr_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ADDR_W-1:0] got_addr_q[$];
  logic [7:0]        got_data_q[$];
  int                wr_cyc = 0;
  int                done_cyc = 0;
  bit                done_seen = 1'b0;

  always @(negedge clk) begin
    if (prog_wr_en === 1'b1) begin
      got_addr_q.push_back(prog_wr_addr);
      got_data_q.push_back(prog_wr_data);
      wr_cyc = cyc;
    end
    if (load_done === 1'b1 && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] stream_q[$];
  int         bad_idx = -1;
  logic [7:0] exp_data_q[$];
  bit         exp_done;
  bit         exp_err;
  int         exp_cnt;

  // Outcome of the bytes sent since start_load, judged from the format alone.
  task automatic run_model();
    int n_good;
    int len;
    int n;
    logic [7:0] x;
    exp_data_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_cnt  = 0;
    n_good = (bad_idx < 0) ? stream_q.size() : bad_idx;
    if (n_good >= 2) begin
      len = int'(stream_q[0]) + 256 * int'(stream_q[1]);
      if (len > (1 << ADDR_W)) begin
        exp_err = 1'b1;
      end else begin
        n = (n_good - 2 < len) ? n_good - 2 : len;
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
          exp_data_q.push_back(stream_q[2 + k]);
          x ^= stream_q[2 + k];
        end
        exp_cnt = n;
        if (n_good - 2 >= len + CK) begin
          if (CK == 1 && stream_q[2 + len] != x) exp_err = 1'b1;
          else exp_done = 1'b1;
        end
      end
    end
    if (!exp_done && !exp_err && bad_idx >= 0) exp_err = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit strike);
    logic [9:0] frame;
    frame = {stop_ok, b, 1'b0};
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      uart_rx    = frame[i / 16];
      start_load = strike && (i == 155);
    end
    @(negedge clk);
    uart_rx    = 1'b1;
    start_load = 1'b0;
  endtask

  task automatic glitch();
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    idle(40);
  endtask

  task automatic send_stream(input int glitch_at);
    for (int i = 0; i < stream_q.size(); i++) begin
      if (i == glitch_at) glitch();
      send_byte(stream_q[i], i != bad_idx, 1'b0);
      idle((i == bad_idx) ? 24 + int'($urandom_range(0, 8)) : int'($urandom_range(2, 12)));
    end
    idle(8);
  endtask

  task automatic clear_obs();
    got_addr_q.delete();
    got_data_q.delete();
    done_seen = 1'b0;
    stream_q.delete();
    bad_idx = -1;
  endtask

  task automatic begin_load();
    @(negedge clk);
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    clear_obs();
  endtask

  task automatic verify(input string tag);
    check({tag, "/nwr"}, got_data_q.size(), exp_data_q.size());
    for (int k = 0; k < got_data_q.size() && k < exp_data_q.size(); k++) begin
      check({tag, "/addr"}, got_addr_q[k], k);
      check({tag, "/data"}, got_data_q[k], exp_data_q[k]);
    end
    check({tag, "/byte_count"}, byte_count, exp_cnt);
    check({tag, "/load_done"}, load_done, exp_done);
    check({tag, "/load_err"}, load_err, exp_err);
    check({tag, "/cpu_hold"}, cpu_hold, !exp_done);
    check({tag, "/wr_en_idle"}, prog_wr_en, 1'b0);
  endtask

  initial begin
    logic [7:0] b0, b1, x;
    int len;
    int n_wr;
    rst = 1'b1;
    uart_rx = 1'b1;
    start_load = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/cpu_hold", cpu_hold, 1'b1);
    check("rst/load_done", load_done, 1'b0);
    check("rst/load_err", load_err, 1'b0);
    check("rst/wr_en", prog_wr_en, 1'b0);
    check("rst/byte_count", byte_count, 0);
    check("rst/addr", prog_wr_addr, 0);
    check("rst/data", prog_wr_data, 0);
    rst = 1'b0;
    idle(5);

    // Bytes arriving before any start_load must be ignored.
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'hA5, 1'b1, 1'b0);
    idle(20);
    check("pre/nwr", got_data_q.size(), 0);
    check("pre/cpu_hold", cpu_hold, 1'b1);
    check("pre/load_done", load_done, 1'b0);

    begin_load();
    stream_q = '{8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    if (CK == 1) stream_q.push_back(8'h13);
    send_stream(-1);
    run_model();
    verify("img4");
    check("img4/done_seen", done_seen, 1'b1);
`ifndef UART_LOADER_CHECKSUM_EN
    check("img4/done_lat", done_cyc - wr_cyc, 1);
`endif

    begin_load();
    stream_q = '{8'h01, 8'h10};
    send_stream(-1);
    run_model();
    verify("len_over");

    begin_load();
    stream_q = '{8'h00, 8'h10};
    send_stream(-1);
    run_model();
    verify("len_cap");

    begin_load();
    stream_q = '{8'h00, 8'h00};
    if (CK == 1) stream_q.push_back(8'h00);
    send_stream(-1);
    run_model();
    verify("len0");

    begin_load();
    stream_q = '{8'h01, 8'h00, 8'hAA};
    bad_idx = 2;
    send_stream(-1);
    run_model();
    verify("ferr");

    begin_load();
    stream_q = '{8'h01, 8'h00, 8'h5A};
    if (CK == 1) stream_q.push_back(8'h5A);
    send_stream(-1);
    run_model();
    verify("ferr_recover");

    // start_load coincident with the 2nd data byte's rx_valid discards it.
    begin_load();
    b0 = 8'($urandom_range(1, 255));
    b1 = 8'($urandom_range(1, 255));
    send_byte(8'h03, 1'b1, 1'b0); idle(4);
    send_byte(8'h00, 1'b1, 1'b0); idle(4);
    send_byte(b0, 1'b1, 1'b0);    idle(4);
    send_byte(b1, 1'b1, 1'b1);    idle(20);
    check("strike/nwr", got_data_q.size(), 1);
    check("strike/data0", got_data_q[0], b0);
    check("strike/byte_count", byte_count, 0);
    check("strike/load_done", load_done, 1'b0);
    check("strike/load_err", load_err, 1'b0);
    check("strike/cpu_hold", cpu_hold, 1'b1);
    clear_obs();
    stream_q = '{8'h01, 8'h00, 8'hC3};
    if (CK == 1) stream_q.push_back(8'hC3);
    send_stream(-1);
    run_model();
    verify("strike_next");

    begin_load();
    stream_q = '{8'h02, 8'h00, 8'h3C, 8'h81};
    if (CK == 1) stream_q.push_back(8'hBD);
    send_stream(2);
    run_model();
    verify("glitch");

    for (int r = 0; r < 8; r++) begin
      begin_load();
      len = int'($urandom_range(1, 6));
      stream_q.push_back(8'(len));
      stream_q.push_back(8'h00);
      x = 8'h00;
      for (int k = 0; k < len; k++) begin
        b0 = 8'($urandom);
        stream_q.push_back(b0);
        x ^= b0;
      end
      if (CK == 1) stream_q.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x);
      if ($urandom_range(0, 4) == 0) bad_idx = int'($urandom_range(0, stream_q.size() - 1));
      send_stream(-1);
      run_model();
      verify("rnd");
    end

    // Asynchronous reset in the middle of DATA.
    begin_load();
    stream_q = '{8'h05, 8'h00, 8'h7E, 8'hE7};
    send_stream(-1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst/wr_en", prog_wr_en, 1'b0);
    check("arst/addr", prog_wr_addr, 0);
    check("arst/data", prog_wr_data, 0);
    check("arst/cpu_hold", cpu_hold, 1'b1);
    check("arst/load_done", load_done, 1'b0);
    check("arst/load_err", load_err, 1'b0);
    check("arst/byte_count", byte_count, 0);
    n_wr = got_data_q.size();
    idle(10);
    rst = 1'b0;
    idle(10);
    check("arst/no_write", got_data_q.size(), n_wr);
    check("arst/hold_after", cpu_hold, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_prog_loader.md
# uart_prog_loader

Serial program loader that sits directly upstream of the instruction BRAM port-A write side and the core's PC control. It receives a length-prefixed byte stream on a UART RX line and writes each byte to consecutive instruction-memory addresses. It holds the core stalled (`cpu_hold`) until the image is complete, then releases it. This allows new programs to run without resynthesising the BRAM init file.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 115_200, UART bit rate; `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division, must be ≥ 4).
- `ADDR_W`, 12, instruction-memory byte address width; capacity `2**ADDR_W` bytes.

Ports:
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `uart_rx` input 1: asynchronous serial line; idles high; 8N1, LSB first.
- `start_load` input 1: one-cycle pulse; (re)arms the loader.
- `prog_wr_en` output 1: one-cycle write strike to the BRAM (`wea`/`ena`).
- `prog_wr_addr` output ADDR_W: byte address for the current write.
- `prog_wr_data` output 8: byte to write.
- `cpu_hold` output 1: high keeps the core stalled (drives `pc_write` low and Ins_buffer reset).
- `load_done` output 1: level; image fully written.
- `load_err` output 1: level; load aborted.
- `byte_count` output ADDR_W+1: data bytes written in the current load.

## Operation
- RX front end:
  - 2-FF synchroniser on `uart_rx`.
  - A falling edge in RX_IDLE starts a bit counter. The line is resampled at `CLKS_PER_BIT/2`; if it is high, this is a false start and the receiver returns to RX_IDLE.
  - The 8 data bits are sampled every `CLKS_PER_BIT`, LSB first.
  - Stop bit: high produces a one-cycle `rx_valid` with the byte. Low sets `load_err` (framing error) and produces no `rx_valid`.
- Loader FSM states: IDLE, LEN_LO, LEN_HI, DATA, (CHK), DONE, ERR.
- IDLE:
  - Entered from reset.
  - `start_load` moves the FSM to LEN_LO.
  - Received bytes are ignored.
- LEN_LO: `rx_valid` latches `len[7:0]`, then the FSM moves to LEN_HI.
- LEN_HI: `rx_valid` latches `len[15:8]`. Next state:
  - `len == 0` goes to DONE (or CHK when the checksum feature is compiled in).
  - `len > 2**ADDR_W` goes to ERR.
  - Otherwise, DATA.
- DATA:
  - Each `rx_valid` asserts `prog_wr_en` for exactly one cycle, with `prog_wr_data = byte` and `prog_wr_addr = byte_count[ADDR_W-1:0]`.
  - `byte_count` increments in that same cycle.
  - When the incremented count equals `len`, the FSM goes to DONE (or CHK).
- DONE: `load_done=1`, `cpu_hold=0`; the FSM stays here until `start_load`.
- ERR: `load_err=1`, `cpu_hold=1`; the FSM stays here until `start_load`.
- `start_load` in any state:
  - The FSM goes to LEN_LO.
  - `byte_count`, `len`, `load_done`, `load_err` and the checksum accumulator clear.
  - `cpu_hold` goes to 1.
  - The RX shifter is not reset.
- A framing error in LEN_LO, LEN_HI, DATA or CHK sends the FSM to ERR. A framing error in IDLE, DONE or ERR is ignored.
- If `start_load` and `rx_valid` occur in the same cycle, `start_load` wins and the byte is discarded.
- Address wrap cannot occur: lengths are bounded to `2**ADDR_W`.

## Timing
- Reset values:
  - Outputs: `prog_wr_en=0`, `prog_wr_addr=0`, `prog_wr_data=0`, `cpu_hold=1`, `load_done=0`, `load_err=0`, `byte_count=0`.
  - Internal state: FSM in IDLE, RX in RX_IDLE.
- `rx_valid` fires in the cycle of the stop-bit mid-sample. This is about 9.5·`CLKS_PER_BIT` + 2 (synchroniser) cycles after the falling edge.
- `prog_wr_en` is registered and is high the cycle after `rx_valid`.
- `load_done` and `cpu_hold` deassert are registered, one cycle after the final write pulse (or one cycle after the final checksum byte when that feature is compiled in).
- Reset mid-operation returns everything to the reset values immediately (asynchronous). No partial write pulse is emitted after `rst` rises.

## Configuration
- `UART_LOADER_CHECKSUM_EN` defined:
  - After the last data byte (or directly after LEN_HI when `len == 0`), state CHK awaits one more byte.
  - The loader keeps an 8-bit XOR of all data bytes.
  - If the received byte equals the accumulator, the FSM goes to DONE; otherwise it goes to ERR.
- `UART_LOADER_CHECKSUM_EN` undefined: no CHK state and no accumulator; the last data byte (or `len == 0`) goes straight to DONE.

## Test plan
All scenarios use `CLK_FREQ=16`, `BAUD=1`, giving `CLKS_PER_BIT=16`.
- Reset, no stimulus -> `cpu_hold=1`, `load_done=0`, `prog_wr_en` never asserts; bytes sent before `start_load` produce no writes.
- `start_load`, then send 0x04, 0x00, 0x13, 0x00, 0x00, 0x00 -> four write pulses at addresses 0..3 with data 13,00,00,00; `byte_count=4`; `load_done=1` and `cpu_hold=0` one cycle after the 4th pulse. With the checksum compiled in, also send 0x13, giving the same result after that byte.
- Length 0x1001 (0x01, 0x10) -> ERR, `load_err=1`, no writes, `cpu_hold=1`.
- Third byte with stop bit driven low -> `load_err=1`, no write for that byte; a later `start_load` followed by a valid 1-byte image gives `load_done=1`.
- 50 % of the way through a 3-byte load, assert `start_load` on the cycle of the 2nd `rx_valid` -> no write for that byte, `byte_count=0`, FSM in LEN_LO.
- Glitch: `uart_rx` low for 4 cycles -> no byte received; `rst` pulse mid-DATA -> all outputs at reset values within the same cycle.
